fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 0, meaning the word address loaded into the program counter (PC) on reset.
REQ-002 SHALL have parameter MEM_DEPTH, default 32, meaning the number of instruction-memory words; PC arithmetic is modulo MEM_DEPTH.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port imem_addr, output, 32 bits: word address to instruction memory; equals PC combinationally.
REQ-006 SHALL have port imem_data, input, 32 bits: instruction word returned combinationally for imem_addr in the same cycle.
REQ-007 SHALL have port branch_taken, input, 1 bit: redirect request from the downstream stage.
REQ-008 SHALL have port branch_target, input, 32 bits: redirect word address, valid while branch_taken=1.
REQ-009 SHALL have port id_ready, input, 1 bit: decode stage accepts id_instr this cycle.
REQ-010 SHALL have port id_valid, output, 1 bit: id_instr/id_pc hold a valid fetched instruction.
REQ-011 SHALL have port id_instr, output, 32 bits: registered instruction word.
REQ-012 SHALL have port id_pc, output, 32 bits: word address of id_instr.
REQ-013 SHALL have port halted, output, 1 bit: fetch permanently stopped (REQ-025).

Function
REQ-014 SHALL define a transfer as id_valid=1 and id_ready=1 in the same cycle.
REQ-015 SHALL capture when id_valid=0 or a transfer occurs, branch_taken=0 and halted=0: id_instr<=imem_data, id_pc<=PC, id_valid<=1, PC<=(PC+1) mod MEM_DEPTH.
REQ-016 SHALL stall when id_valid=1, id_ready=0 and branch_taken=0: PC, id_instr, id_pc and id_valid all unchanged.
REQ-017 SHALL give branch_taken=1 priority over capture and stall: PC<=branch_target mod MEM_DEPTH, id_valid<=0, id_instr/id_pc unchanged, no capture that cycle.
REQ-018 SHALL, on branch_taken=1 coinciding with a transfer, complete the transfer and apply only the redirect (the instruction presented by imem_data that cycle is discarded).
REQ-019 SHALL fetch from the redirected PC on the cycle after a redirect; redirect-to-valid latency is 1 cycle.
REQ-020 SHALL, with id_valid=0, no redirect and no halt, keep id_ready from affecting capture.
REQ-021 SHALL wrap PC from MEM_DEPTH-1 to 0 without any other side effect.
REQ-022 SHALL provide one-instruction-per-cycle throughput while id_ready=1 and no redirect.
REQ-023 SHALL hold id_valid stable until transfer or redirect; id_instr/id_pc SHALL NOT change while id_valid=1 and id_ready=0.

Reset
REQ-024 SHALL, on reset=1 at a clock edge, set PC=RESET_PC mod MEM_DEPTH, id_valid=0, id_instr=0, id_pc=0, halted=0; reset overrides branch_taken, capture and halt, including mid-stall.

Configuration
REQ-025 SHALL, with macro FETCH_HALT_DETECT_EN defined, set halted<=1 in the same edge that captures a word with bits[31:26]=6'b111111; thereafter no capture, PC frozen, branch_taken ignored, id_valid/id_instr retire normally via transfer; halted clears only on reset.
REQ-026 SHALL, without FETCH_HALT_DETECT_EN, tie halted to 0 and treat opcode 6'b111111 as an ordinary instruction.

Verification
REQ-027 Reset, RESET_PC=0, id_ready=1, memory word n = n -> cycles 1..4 after reset: id_instr=0,1,2,3, id_pc=0,1,2,3, id_valid=1 each cycle.
REQ-028 id_ready=0 for 3 cycles with id_pc=2 -> id_instr/id_pc/id_valid held, imem_addr stays 3; id_ready=1 -> next id_pc=3.
REQ-029 branch_taken=1, branch_target=7 while stalled at id_pc=4 -> next cycle id_valid=0, imem_addr=7; following cycle id_pc=7, id_valid=1.
REQ-030 MEM_DEPTH=32, RESET_PC=30, id_ready=1 -> id_pc sequence 30,31,0,1; branch_target=33 -> fetch resumes at 1.
REQ-031 FETCH_HALT_DETECT_EN, word 5 = 32'hFC00_0000 -> halted=1 when id_pc=5 captured, imem_addr frozen at 6, branch_taken ignored, id_valid drops after transfer; reset clears halted and restarts at RESET_PC.
REQ-032 reset asserted while id_valid=1, id_ready=0, branch_taken=1 -> next cycle id_valid=0, id_instr=0, PC=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, registered instruction to decode, redirect and stall handling.
// Optional halt-opcode detection is enabled by defining FETCH_HALT_DETECT_EN.
module fetch_unit #(
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned MEM_DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        halted
);

  localparam logic [31:0] DEPTH      = 32'(MEM_DEPTH);
  localparam logic [31:0] RESET_WORD = 32'(RESET_PC % MEM_DEPTH);

  logic [31:0] pc;
  logic [31:0] pc_plus1;
  logic [31:0] target_wrapped;
  logic        transfer;
  logic        redirect;
  logic        capture;

  assign imem_addr      = pc;
  assign transfer       = id_valid && id_ready;
  assign pc_plus1       = (pc == DEPTH - 32'd1) ? 32'd0 : pc + 32'd1;
  assign target_wrapped = branch_target % DEPTH;

  // Once halted, redirects are ignored and nothing new is captured.
  assign redirect = branch_taken && !halted;
  assign capture  = !redirect && !halted && (!id_valid || transfer);

`ifdef FETCH_HALT_DETECT_EN
  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  logic halt_hit;
  assign halt_hit = capture && (imem_data[31:26] == HALT_OPCODE);

  always_ff @(posedge clk) begin
    if (reset)
      halted <= 1'b0;
    else if (halt_hit)
      halted <= 1'b1;
  end
`else
  assign halted = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of pc/id_valid regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_WORD;
      id_valid <= 1'b0;
      id_instr <= 32'd0;
      id_pc    <= 32'd0;
    end else if (redirect) begin
      // A coincident transfer completes; the word on imem_data is dropped.
      pc       <= target_wrapped;
      id_valid <= 1'b0;
    end else if (capture) begin
      id_instr <= imem_data;
      id_pc    <= pc;
      id_valid <= 1'b1;
      pc       <= pc_plus1;
    end else if (transfer) begin
      // Only reachable while halted: the last word retires and fetch stays idle.
      id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected transfers, a monitor
// pops and compares them on every id_valid/id_ready handshake; direct checks cover the rest.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        halted;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } xfer_t;

  xfer_t exp_q[$];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(0), .MEM_DEPTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .id_ready     (id_ready),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .halted       (halted)
  );

  // Memory model: word n holds n, except word 5 holds a halt-opcode word.
  function automatic logic [31:0] word_at(input logic [31:0] addr);
    return (addr == 32'd5) ? 32'hFC00_0000 : addr;
  endfunction

  assign imem_data = word_at(imem_addr);

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic expect_xfer(input logic [31:0] p);
    exp_q.push_back('{pc: p, instr: word_at(p)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Monitor: every handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (id_valid === 1'b1 && id_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer: got id_pc=0x%08h, expected no transfer", id_pc);
      end else begin
        xfer_t e;
        e = exp_q.pop_front();
        check("xfer_pc", id_pc, e.pc);
        check("xfer_instr", id_instr, e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    id_ready      = 1'b1;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    step();
    step();
    reset = 1'b0;
    sample();
    check("reset_valid", 32'(id_valid), 32'd0);
    check("reset_instr", id_instr, 32'd0);
    check("reset_pc", id_pc, 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_addr", imem_addr, 32'd0);

    // Streaming, then a three-cycle stall holding id_pc=2.
    expect_xfer(0);
    expect_xfer(1);
    step();
    step();
    step();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("stall_pc", id_pc, 32'd2);
      check("stall_instr", id_instr, 32'd2);
      check("stall_valid", 32'(id_valid), 32'd1);
      check("stall_addr", imem_addr, 32'd3);
      step();
    end
    id_ready = 1'b1;
    expect_xfer(2);
    expect_xfer(3);
    step();
    step();

    // Redirect to 7 while stalled at id_pc=4.
    id_ready      = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'd7;
    sample();
    check("br_stall_pc", id_pc, 32'd4);
    step();
    branch_taken = 1'b0;
    sample();
    check("br_valid", 32'(id_valid), 32'd0);
    check("br_addr", imem_addr, 32'd7);
    check("br_keep_pc", id_pc, 32'd4);
    step();
    sample();
    check("br_resume_pc", id_pc, 32'd7);
    check("br_resume_valid", 32'(id_valid), 32'd1);

    // Redirect coinciding with a transfer of id_pc=8.
    step();
    id_ready = 1'b1;
    expect_xfer(7);
    expect_xfer(8);
    step();
    branch_taken  = 1'b1;
    branch_target = 32'd30;
    step();
    branch_taken = 1'b0;
    sample();
    check("xbr_valid", 32'(id_valid), 32'd0);
    check("xbr_addr", imem_addr, 32'd30);
    check("xbr_pc", id_pc, 32'd8);

    // Wrap 30,31,0,1 then redirect to 33 (mod 32 = 1).
    expect_xfer(30);
    expect_xfer(31);
    expect_xfer(0);
    expect_xfer(1);
    step();
    step();
    step();
    step();
    branch_taken  = 1'b1;
    branch_target = 32'd33;
    step();
    branch_taken = 1'b0;
    sample();
    check("wrap_br_valid", 32'(id_valid), 32'd0);
    check("wrap_br_addr", imem_addr, 32'd1);
    for (int p = 1; p <= 5; p++) expect_xfer(32'(p));
    for (int i = 0; i < 5; i++) step();
    sample();
    check("addr_after5", imem_addr, 32'd6);

`ifdef FETCH_HALT_DETECT_EN
    check("halt_set", 32'(halted), 32'd1);
    step();
    branch_taken  = 1'b1;
    branch_target = 32'd10;
    sample();
    check("halt_retired", 32'(id_valid), 32'd0);
    check("halt_hold", 32'(halted), 32'd1);
    check("halt_addr", imem_addr, 32'd6);
    step();
    branch_taken = 1'b0;
    sample();
    check("halt_br_ignored", imem_addr, 32'd6);
    check("halt_br_valid", 32'(id_valid), 32'd0);
`else
    check("no_halt", 32'(halted), 32'd0);
    expect_xfer(6);
    step();
    step();
    id_ready = 1'b0;
    sample();
    check("nohalt_pc", id_pc, 32'd7);
    check("nohalt_instr", id_instr, 32'd7);
    check("nohalt_halted", 32'(halted), 32'd0);
`endif

    // Reset restarts at RESET_PC and clears halted.
    step();
    reset        = 1'b1;
    id_ready     = 1'b0;
    branch_taken = 1'b0;
    step();
    reset = 1'b0;
    sample();
    check("rst2_halted", 32'(halted), 32'd0);
    check("rst2_valid", 32'(id_valid), 32'd0);
    check("rst2_addr", imem_addr, 32'd0);
    step();
    id_ready = 1'b1;
    expect_xfer(0);
    expect_xfer(1);
    step();
    step();

    // Reset during a stall with a redirect pending.
    id_ready      = 1'b0;
    reset         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'd12;
    sample();
    check("pre_rst_pc", id_pc, 32'd2);
    check("pre_rst_valid", 32'(id_valid), 32'd1);
    step();
    reset        = 1'b0;
    branch_taken = 1'b0;
    sample();
    check("rst3_valid", 32'(id_valid), 32'd0);
    check("rst3_instr", id_instr, 32'd0);
    check("rst3_pc", id_pc, 32'd0);
    check("rst3_addr", imem_addr, 32'd0);
    check("rst3_halted", 32'(halted), 32'd0);
    step();
    id_ready = 1'b1;
    expect_xfer(0);
    step();
    id_ready = 1'b0;
    sample();
    check("final_pc", id_pc, 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
